// File: rtl/reg_file_renamed_pkg.sv
// Shared definitions for the register file, ROB and reservation stations.
package reg_file_renamed_pkg;

  localparam int unsigned RfXlen  = 32;
  localparam int unsigned RfNreg  = 32;
  localparam int unsigned RfAw    = 5;
  localparam int unsigned RobTagW = 4;

  typedef logic [RobTagW-1:0] rob_tag_t;
  typedef logic [RfAw-1:0]    reg_idx_t;

endpackage

// File: rtl/rf_status_table.sv
// Rename status per architectural register: busy bit plus producing ROB tag.
// Lookups return the post-commit, post-flush, pre-rename view.
module rf_status_table #(
  parameter int unsigned NREG  = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             ren_valid_i,
  input  logic [AW-1:0]    ren_rd_i,
  input  logic [TAG_W-1:0] ren_tag_i,
  input  logic             cm_valid_i,
  input  logic [AW-1:0]    cm_rd_i,
  input  logic [TAG_W-1:0] cm_tag_i,
  input  logic             flush_i,
  input  logic [AW-1:0]    rd_rs1_i,
  input  logic [AW-1:0]    rd_rs2_i,
  output logic             rs1_busy_o,
  output logic [TAG_W-1:0] rs1_tag_o,
  output logic             rs2_busy_o,
  output logic [TAG_W-1:0] rs2_tag_o
);

  logic [NREG-1:0]  busy_q, busy_d, busy_post;
  logic [TAG_W-1:0] tag_q [NREG];
  logic [TAG_W-1:0] tag_d [NREG];

  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      busy_post[i] = busy_q[i];
      // Only the current producer may clear busy; stale commits leave it set.
      if (cm_valid_i && (cm_rd_i == AW'(i)) && (i != 0) && (tag_q[i] == cm_tag_i)) begin
        busy_post[i] = 1'b0;
      end
      if (flush_i) begin
        busy_post[i] = 1'b0;
      end
    end

    busy_d = busy_post;
    tag_d  = tag_q;
    if (!flush_i && ren_valid_i && (ren_rd_i != '0)) begin
      busy_d[ren_rd_i] = 1'b1;
      tag_d[ren_rd_i]  = ren_tag_i;
    end
  end

  assign rs1_busy_o = (rd_rs1_i != '0) && busy_post[rd_rs1_i];
  assign rs2_busy_o = (rd_rs2_i != '0) && busy_post[rd_rs2_i];
  assign rs1_tag_o  = (rd_rs1_i == '0) ? '0 : tag_q[rd_rs1_i];
  assign rs2_tag_o  = (rd_rs2_i == '0) ? '0 : tag_q[rd_rs2_i];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
      for (int unsigned i = 0; i < NREG; i++) begin
        tag_q[i] <= '0;
      end
    end else if (en_i) begin
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

endmodule

// File: rtl/reg_file_renamed.sv
// Architectural register file with rename status, commit bypass and flush,
// serving two registered source reads per cycle to the issue path.
module reg_file_renamed
  import reg_file_renamed_pkg::*;
#(
  parameter int unsigned XLEN  = RfXlen,
  parameter int unsigned NREG  = RfNreg,
  parameter int unsigned AW    = RfAw,
  parameter int unsigned TAG_W = RobTagW
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             rd_req,
  input  logic [AW-1:0]    rd_rs1,
  input  logic [AW-1:0]    rd_rs2,
  output logic             rd_ack,
  output logic [XLEN-1:0]  rs1_val,
  output logic             rs1_busy,
  output logic [TAG_W-1:0] rs1_tag,
  output logic [XLEN-1:0]  rs2_val,
  output logic             rs2_busy,
  output logic [TAG_W-1:0] rs2_tag,
  input  logic             ren_valid,
  input  logic [AW-1:0]    ren_rd,
  input  logic [TAG_W-1:0] ren_tag,
  input  logic             cm_valid,
  input  logic [AW-1:0]    cm_rd,
  input  logic [TAG_W-1:0] cm_tag,
  input  logic [XLEN-1:0]  cm_data,
  input  logic             flush
);

  logic [XLEN-1:0]  regs_q [NREG];
  logic [XLEN-1:0]  regs_d [NREG];

  logic             rd_ack_q, rd_ack_d;
  logic [XLEN-1:0]  rs1_val_q, rs1_val_d, rs2_val_q, rs2_val_d;
  logic             rs1_busy_q, rs1_busy_d, rs2_busy_q, rs2_busy_d;
  logic [TAG_W-1:0] rs1_tag_q, rs1_tag_d, rs2_tag_q, rs2_tag_d;

  logic             st_rs1_busy, st_rs2_busy;
  logic [TAG_W-1:0] st_rs1_tag, st_rs2_tag;

  rf_status_table #(
    .NREG  (NREG),
    .AW    (AW),
    .TAG_W (TAG_W)
  ) u_status (
    .clk_i       (clk_in),
    .rst_i       (rst_in),
    .en_i        (rdy_in),
    .ren_valid_i (ren_valid),
    .ren_rd_i    (ren_rd),
    .ren_tag_i   (ren_tag),
    .cm_valid_i  (cm_valid),
    .cm_rd_i     (cm_rd),
    .cm_tag_i    (cm_tag),
    .flush_i     (flush),
    .rd_rs1_i    (rd_rs1),
    .rd_rs2_i    (rd_rs2),
    .rs1_busy_o  (st_rs1_busy),
    .rs1_tag_o   (st_rs1_tag),
    .rs2_busy_o  (st_rs2_busy),
    .rs2_tag_o   (st_rs2_tag)
  );

  always_comb begin
    regs_d = regs_q;
    if (cm_valid && (cm_rd != '0)) begin
      regs_d[cm_rd] = cm_data;
    end

    rd_ack_d   = rd_req;
    rs1_val_d  = rs1_val_q;
    rs1_busy_d = rs1_busy_q;
    rs1_tag_d  = rs1_tag_q;
    rs2_val_d  = rs2_val_q;
    rs2_busy_d = rs2_busy_q;
    rs2_tag_d  = rs2_tag_q;
    // Reading regs_d gives the commit bypass for free.
    if (rd_req) begin
      rs1_val_d  = (rd_rs1 == '0) ? '0 : regs_d[rd_rs1];
      rs1_busy_d = st_rs1_busy;
      rs1_tag_d  = st_rs1_tag;
      rs2_val_d  = (rd_rs2 == '0) ? '0 : regs_d[rd_rs2];
      rs2_busy_d = st_rs2_busy;
      rs2_tag_d  = st_rs2_tag;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      rd_ack_q   <= 1'b0;
      rs1_val_q  <= '0;
      rs1_busy_q <= 1'b0;
      rs1_tag_q  <= '0;
      rs2_val_q  <= '0;
      rs2_busy_q <= 1'b0;
      rs2_tag_q  <= '0;
    end else if (rdy_in) begin
      regs_q     <= regs_d;
      rd_ack_q   <= rd_ack_d;
      rs1_val_q  <= rs1_val_d;
      rs1_busy_q <= rs1_busy_d;
      rs1_tag_q  <= rs1_tag_d;
      rs2_val_q  <= rs2_val_d;
      rs2_busy_q <= rs2_busy_d;
      rs2_tag_q  <= rs2_tag_d;
    end
  end

  assign rd_ack   = rd_ack_q;
  assign rs1_val  = rs1_val_q;
  assign rs1_busy = rs1_busy_q;
  assign rs1_tag  = rs1_tag_q;
  assign rs2_val  = rs2_val_q;
  assign rs2_busy = rs2_busy_q;
  assign rs2_tag  = rs2_tag_q;

endmodule

// File: tb/tb_reg_file_renamed.sv
// Directed vector table plus randomized traffic against a sequential-rule model.
module tb_reg_file_renamed;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, rd_req;
  logic [4:0]  rd_rs1, rd_rs2;
  logic        rd_ack;
  logic [31:0] rs1_val, rs2_val;
  logic        rs1_busy, rs2_busy;
  logic [3:0]  rs1_tag, rs2_tag;
  logic        ren_valid;
  logic [4:0]  ren_rd;
  logic [3:0]  ren_tag;
  logic        cm_valid;
  logic [4:0]  cm_rd;
  logic [3:0]  cm_tag;
  logic [31:0] cm_data;
  logic        flush;

  int errors = 0;
  int checks = 0;

  always #5 clk_in = ~clk_in;

  reg_file_renamed dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .rd_req    (rd_req),
    .rd_rs1    (rd_rs1),
    .rd_rs2    (rd_rs2),
    .rd_ack    (rd_ack),
    .rs1_val   (rs1_val),
    .rs1_busy  (rs1_busy),
    .rs1_tag   (rs1_tag),
    .rs2_val   (rs2_val),
    .rs2_busy  (rs2_busy),
    .rs2_tag   (rs2_tag),
    .ren_valid (ren_valid),
    .ren_rd    (ren_rd),
    .ren_tag   (ren_tag),
    .cm_valid  (cm_valid),
    .cm_rd     (cm_rd),
    .cm_tag    (cm_tag),
    .cm_data   (cm_data),
    .flush     (flush)
  );

  typedef struct {
    int unsigned rdy, req, rs1, rs2;
    int unsigned ren_v, ren_rd, ren_tag;
    int unsigned cm_v, cm_rd, cm_tag, cm_data;
    int unsigned flush;
    int unsigned e_ack, e_v1, e_b1, e_t1, e_v2, e_b2, e_t2;
  } vec_t;

  vec_t vecs[23];

  // Reference state: committed values, busy flags, producer tags, last response.
  logic [31:0] m_val [32];
  logic        m_busy[32];
  logic [3:0]  m_tag [32];
  logic        e_ack, e_b1, e_b2;
  logic [31:0] e_v1, e_v2;
  logic [3:0]  e_t1, e_t2;

  task automatic check(input string name, input logic ack_e, input logic cmp_data,
                       input logic [31:0] v1, input logic b1, input logic [3:0] t1,
                       input logic [31:0] v2, input logic b2, input logic [3:0] t2);
    logic bad;
    checks++;
    bad = (rd_ack !== ack_e);
    if (cmp_data) begin
      bad = bad || (rs1_val !== v1) || (rs1_busy !== b1) || (rs1_tag !== t1) ||
            (rs2_val !== v2) || (rs2_busy !== b2) || (rs2_tag !== t2);
    end
    if (bad) begin
      errors++;
      $display("FAIL %s: got ack=%b v1=%h b1=%b t1=%0d v2=%h b2=%b t2=%0d; want ack=%b v1=%h b1=%b t1=%0d v2=%h b2=%b t2=%0d",
               name, rd_ack, rs1_val, rs1_busy, rs1_tag, rs2_val, rs2_busy, rs2_tag,
               ack_e, v1, b1, t1, v2, b2, t2);
    end
  endtask

  task automatic idle_inputs();
    rst_in = 1'b0; rdy_in = 1'b1; rd_req = 1'b0; rd_rs1 = '0; rd_rs2 = '0;
    ren_valid = 1'b0; ren_rd = '0; ren_tag = '0;
    cm_valid = 1'b0; cm_rd = '0; cm_tag = '0; cm_data = '0; flush = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    rdy_in = v.rdy[0]; rd_req = v.req[0]; rd_rs1 = 5'(v.rs1); rd_rs2 = 5'(v.rs2);
    ren_valid = v.ren_v[0]; ren_rd = 5'(v.ren_rd); ren_tag = 4'(v.ren_tag);
    cm_valid = v.cm_v[0]; cm_rd = 5'(v.cm_rd); cm_tag = 4'(v.cm_tag); cm_data = v.cm_data;
    flush = v.flush[0];
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
    end
    e_ack = 1'b0; e_v1 = '0; e_b1 = 1'b0; e_t1 = '0; e_v2 = '0; e_b2 = 1'b0; e_t2 = '0;
  endtask

  // Apply one cycle's rules in order: commit, flush, read, rename.
  task automatic model_step();
    int r1, r2;
    if (rst_in) begin
      model_reset();
      return;
    end
    if (!rdy_in) return;
    if (cm_valid && cm_rd != 0) begin
      m_val[cm_rd] = cm_data;
      if (m_busy[cm_rd] && m_tag[cm_rd] == cm_tag) m_busy[cm_rd] = 1'b0;
    end
    if (flush) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end
    e_ack = rd_req;
    if (rd_req) begin
      r1 = int'(rd_rs1);
      r2 = int'(rd_rs2);
      e_v1 = (r1 == 0) ? 32'h0 : m_val[r1];
      e_b1 = (r1 == 0) ? 1'b0 : m_busy[r1];
      e_t1 = (r1 == 0) ? 4'h0 : m_tag[r1];
      e_v2 = (r2 == 0) ? 32'h0 : m_val[r2];
      e_b2 = (r2 == 0) ? 1'b0 : m_busy[r2];
      e_t2 = (r2 == 0) ? 4'h0 : m_tag[r2];
    end
    if (!flush && ren_valid && ren_rd != 0) begin
      m_busy[ren_rd] = 1'b1;
      m_tag[ren_rd]  = ren_tag;
    end
  endtask

  initial begin
    // rdy req rs1 rs2 | ren v rd tag | cm v rd tag data | flush | ack v1 b1 t1 v2 b2 t2
    vecs[0]  = '{1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0,            0, 1, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 0, 1, 3, 7, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0,            0, 1, 0, 1, 7, 0, 0, 0};
    vecs[3]  = '{1, 1, 3, 0, 0, 0, 0, 1, 3, 7, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 0, 7, 0, 0, 0};
    vecs[4]  = '{1, 0, 0, 0, 1, 3, 2, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0};
    vecs[5]  = '{1, 0, 0, 0, 1, 3, 5, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0};
    vecs[6]  = '{1, 1, 3, 0, 0, 0, 0, 1, 3, 2, 32'h11,       0, 1, 32'h11, 1, 5, 0, 0, 0};
    vecs[7]  = '{1, 1, 3, 3, 0, 0, 0, 0, 0, 0, 0,            0, 1, 32'h11, 1, 5, 32'h11, 1, 5};
    vecs[8]  = '{1, 1, 4, 3, 1, 4, 9, 0, 0, 0, 0,            0, 1, 0, 0, 0, 32'h11, 1, 5};
    vecs[9]  = '{1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0,            0, 1, 0, 1, 9, 0, 0, 0};
    vecs[10] = '{1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0};
    vecs[11] = '{1, 0, 0, 0, 1, 2, 2, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0};
    vecs[12] = '{1, 1, 1, 2, 1, 6, 6, 0, 0, 0, 0,            1, 1, 0, 0, 1, 0, 0, 2};
    vecs[13] = '{1, 1, 6, 3, 0, 0, 0, 0, 0, 0, 0,            0, 1, 0, 0, 0, 32'h11, 0, 5};
    vecs[14] = '{1, 1, 4, 2, 0, 0, 0, 0, 0, 0, 0,            0, 1, 0, 0, 9, 0, 0, 2};
    vecs[15] = '{1, 1, 0, 0, 1, 0, 3, 1, 0, 3, 32'h55,       0, 1, 0, 0, 0, 0, 0, 0};
    vecs[16] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,            0, 1, 0, 0, 0, 0, 0, 0};
    vecs[17] = '{0, 1, 3, 3, 0, 0, 0, 1, 5, 0, 32'h77,       0, 1, 0, 0, 0, 0, 0, 0};
    vecs[18] = '{1, 1, 5, 3, 0, 0, 0, 0, 0, 0, 0,            0, 1, 0, 0, 0, 32'h11, 0, 5};
    vecs[19] = '{1, 0, 0, 0, 1, 7, 4, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0};
    vecs[20] = '{1, 1, 7, 0, 0, 0, 0, 1, 7, 9, 32'hAB,       1, 1, 32'hAB, 0, 4, 0, 0, 0};
    vecs[21] = '{1, 1, 7, 7, 0, 0, 0, 0, 0, 0, 0,            0, 1, 32'hAB, 0, 4, 32'hAB, 0, 4};
    vecs[22] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0};

    idle_inputs();
    rst_in = 1'b1;
    tick();
    tick();
    check("reset", 1'b0, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0);
    rst_in = 1'b0;

    for (int k = 0; k < 23; k++) begin
      apply(vecs[k]);
      tick();
      check($sformatf("vec%0d", k), vecs[k].e_ack[0], vecs[k].e_ack[0],
            vecs[k].e_v1, vecs[k].e_b1[0], 4'(vecs[k].e_t1),
            vecs[k].e_v2, vecs[k].e_b2[0], 4'(vecs[k].e_t2));
    end

    // Reset while a read is requested and rdy_in is low still clears everything.
    idle_inputs();
    rd_req = 1'b1; rd_rs1 = 5'd3; rd_rs2 = 5'd7; rdy_in = 1'b0; rst_in = 1'b1;
    tick();
    check("reset_mid_op", 1'b0, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0);
    idle_inputs();
    rd_req = 1'b1; rd_rs1 = 5'd3; rd_rs2 = 5'd7;
    tick();
    check("after_reset_read", 1'b1, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0);

    model_reset();
    idle_inputs();
    rst_in = 1'b1;
    tick();
    for (int n = 0; n < 800; n++) begin
      rst_in    = ($urandom_range(0, 99) == 0);
      rdy_in    = ($urandom_range(0, 7) != 0);
      rd_req    = ($urandom_range(0, 3) != 0);
      rd_rs1    = 5'($urandom_range(0, 7));
      rd_rs2    = 5'($urandom_range(0, 7));
      ren_valid = ($urandom_range(0, 1) == 1);
      ren_rd    = 5'($urandom_range(0, 7));
      ren_tag   = 4'($urandom_range(0, 15));
      cm_valid  = ($urandom_range(0, 1) == 1);
      cm_rd     = 5'($urandom_range(0, 7));
      cm_tag    = ($urandom_range(0, 1) == 1) ? m_tag[cm_rd] : 4'($urandom_range(0, 15));
      cm_data   = $urandom;
      flush     = ($urandom_range(0, 15) == 0);
      model_step();
      tick();
      check($sformatf("rand%0d", n), e_ack, 1'b1, e_v1, e_b1, e_t1, e_v2, e_b2, e_t2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
